// File: rtl/rl_ram_1r1w_generic.sv
// Generic single-clock 1R1W RAM with byte-lane enables, 1/2-cycle read latency,
// defined read-during-write behaviour, read-valid strobe and optional post-reset clear.
module rl_ram_1r1w_generic #(
    parameter int ABITS   = 10,
    parameter int DBITS   = 32,
    parameter int BBITS   = 8,
    parameter int LATENCY = 1,
    parameter int CLEAR   = 0,
    parameter     RDW     = "NEW",
    localparam int BBSAFE = (BBITS < 1) ? 1 : BBITS,
    localparam int BEW    = (DBITS + BBSAFE - 1) / BBSAFE
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [ABITS-1:0] waddr,
    input  logic [DBITS-1:0] din,
    input  logic             we,
    input  logic [BEW-1:0]   be,
    input  logic [ABITS-1:0] raddr,
    input  logic             re,
    output logic [DBITS-1:0] dout,
    output logic             dout_valid,
    output logic             busy
);

    // state    | meaning
    // ST_IDLE  | normal operation, reads and writes accepted
    // ST_CLR   | zeroing one word per clock from address 0 upward, busy=1

    localparam int DEPTH   = 2 ** ABITS;
    localparam bit RDW_NEW = (RDW == "NEW");
    localparam bit RDW_OLD = (RDW == "OLD");

    if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
        $error("rl_ram_1r1w_generic: LATENCY must be 1 or 2");
    end
    if (BBITS < 1) begin : g_bad_bbits
        $error("rl_ram_1r1w_generic: BBITS must be at least 1");
    end
    if (!RDW_NEW && !RDW_OLD) begin : g_bad_rdw
        $error("rl_ram_1r1w_generic: RDW must be \"NEW\" or \"OLD\"");
    end

    typedef enum logic {ST_IDLE = 1'b0, ST_CLR = 1'b1} state_t;

    state_t           state;
    logic [ABITS-1:0] clr_addr;
    logic [DBITS-1:0] mem [DEPTH];
    logic [DBITS-1:0] wmask;
    logic [DBITS-1:0] rd_mem;
    logic [DBITS-1:0] rd_word;
    logic             wr_acc;
    logic             rd_acc;
    logic             clr_we;
    logic             hit;

    // Expand lane enables to a per-bit mask; the top lane may be partial.
    for (genvar i = 0; i < DBITS; i++) begin : g_mask
        assign wmask[i] = be[i / BBSAFE];
    end

    assign wr_acc = rstn & we & ~busy;
    assign rd_acc = rstn & re & ~busy;
    assign clr_we = rstn & (state == ST_CLR);

    assign rd_mem  = mem[raddr];
    assign hit     = RDW_NEW & wr_acc & (raddr == waddr);
    assign rd_word = hit ? ((rd_mem & ~wmask) | (din & wmask)) : rd_mem;

    if (CLEAR != 0) begin : g_clr
        always_ff @(posedge clk) begin
            if (!rstn) begin
                state    <= ST_CLR;
                clr_addr <= '0;
                busy     <= 1'b1;
            end else if (state == ST_CLR) begin
                clr_addr <= clr_addr + ABITS'(1);
                if (clr_addr == {ABITS{1'b1}}) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            end
        end
    end else begin : g_noclr
        assign state    = ST_IDLE;
        assign clr_addr = '0;
        assign busy     = 1'b0;
    end

    // Array has no reset; only the clear sequencer or accepted writes touch it.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc) begin
            mem[waddr] <= (mem[waddr] & ~wmask) | (din & wmask);
        end
    end

    if (LATENCY == 2) begin : g_lat2
        logic [DBITS-1:0] rd_d_q;
        logic             rd_v_q;

        // Data is captured at the accept edge, so a later write cannot disturb it.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                rd_d_q     <= '0;
                rd_v_q     <= 1'b0;
                dout       <= '0;
                dout_valid <= 1'b0;
            end else begin
                rd_v_q     <= rd_acc;
                dout_valid <= rd_v_q;
                if (rd_acc) rd_d_q <= rd_word;
                if (rd_v_q) dout   <= rd_d_q;
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk) begin
            if (!rstn) begin
                dout       <= '0;
                dout_valid <= 1'b0;
            end else begin
                dout_valid <= rd_acc;
                if (rd_acc) dout <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_rl_ram_1r1w_generic.sv
// Bench for rl_ram_1r1w_generic: three configurations driven by one stimulus stream,
// checked every cycle against a word-array model plus literal expectations.
module tb_rl_ram_1r1w_generic;

    logic        clk = 1'b0;
    logic        rstn;
    logic        we, re;
    logic [3:0]  waddr, raddr;
    logic [31:0] din;
    logic [3:0]  be;

    logic [31:0] dout0, dout1;
    logic [11:0] dout2;
    logic        dv0, dv1, dv2;
    logic        busy0, busy1, busy2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // u0: latency 1, clear, NEW. u1: latency 2, clear, OLD. u2: 12-bit, no clear, NEW.
    rl_ram_1r1w_generic #(.ABITS(4), .DBITS(32), .BBITS(8), .LATENCY(1), .CLEAR(1), .RDW("NEW")) u0 (
        .clk(clk), .rstn(rstn), .waddr(waddr), .din(din), .we(we), .be(be),
        .raddr(raddr), .re(re), .dout(dout0), .dout_valid(dv0), .busy(busy0));

    rl_ram_1r1w_generic #(.ABITS(4), .DBITS(32), .BBITS(8), .LATENCY(2), .CLEAR(1), .RDW("OLD")) u1 (
        .clk(clk), .rstn(rstn), .waddr(waddr), .din(din), .we(we), .be(be),
        .raddr(raddr), .re(re), .dout(dout1), .dout_valid(dv1), .busy(busy1));

    rl_ram_1r1w_generic #(.ABITS(4), .DBITS(12), .BBITS(8), .LATENCY(1), .CLEAR(0), .RDW("NEW")) u2 (
        .clk(clk), .rstn(rstn), .waddr(waddr), .din(din[11:0]), .we(we), .be(be[1:0]),
        .raddr(raddr), .re(re), .dout(dout2), .dout_valid(dv2), .busy(busy2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model
    int          lat_p [3] = '{1, 2, 1};
    int          clr_p [3] = '{1, 1, 0};
    int          new_p [3] = '{1, 0, 1};
    logic [31:0] dmsk  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0FFF};
    logic [31:0] m     [3][16];
    int          clr_left [3];
    logic [31:0] ed [3];
    logic        ev [3];
    logic [31:0] pd [3];
    logic        pv [3];

    function automatic logic [31:0] lmask(input logic [3:0] b);
        logic [31:0] r;
        for (int j = 0; j < 32; j++) r[j] = b[j / 8];
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 16; j++) m[i][j] = '0;
            clr_left[i] = 0; ed[i] = '0; ev[i] = 1'b0; pd[i] = '0; pv[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!rstn) begin
                    clr_left[i] = (clr_p[i] != 0) ? 16 : 0;
                    ed[i] = '0; ev[i] = 1'b0; pd[i] = '0; pv[i] = 1'b0;
                end else begin
                    logic        bsy, aw, ar;
                    logic [31:0] mk, rdv;
                    bsy = (clr_left[i] != 0);
                    aw  = we && !bsy;
                    ar  = re && !bsy;
                    mk  = lmask(be) & dmsk[i];
                    rdv = m[i][raddr];
                    if (aw && raddr == waddr && new_p[i] != 0)
                        rdv = (rdv & ~mk) | (din & mk);
                    if (lat_p[i] == 1) begin
                        if (ar) ed[i] = rdv;
                        ev[i] = ar;
                    end else begin
                        if (pv[i]) ed[i] = pd[i];
                        ev[i] = pv[i];
                        pv[i] = ar;
                        if (ar) pd[i] = rdv;
                    end
                    if (aw) m[i][waddr] = (m[i][waddr] & ~mk) | (din & mk);
                    if (clr_left[i] != 0) begin
                        clr_left[i]--;
                        if (clr_left[i] == 0)
                            for (int j = 0; j < 16; j++) m[i][j] = '0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                logic [31:0] ad [3];
                logic        av [3];
                logic        ab [3];
                ad[0] = dout0; ad[1] = dout1; ad[2] = {20'd0, dout2};
                av[0] = dv0;   av[1] = dv1;   av[2] = dv2;
                ab[0] = busy0; ab[1] = busy1; ab[2] = busy2;
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("u%0d dout", i), ad[i], ed[i]);
                    chk($sformatf("u%0d dout_valid", i), {31'd0, av[i]}, {31'd0, ev[i]});
                    chk($sformatf("u%0d busy", i), {31'd0, ab[i]}, {31'd0, clr_left[i] != 0});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        we = 1'b0; re = 1'b0; be = '0; din = '0; waddr = '0; raddr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        idle();
        we = 1'b1; waddr = a; din = d; be = b;
        tick();
    endtask

    task automatic rd(input logic [3:0] a);
        idle();
        re = 1'b1; raddr = a;
        tick();
    endtask

    initial begin
        int n, pulses;
        rstn = 1'b0;
        idle();
        @(negedge clk);
        tick();
        tick();
        chk_en = 1'b1;
        chk("reset busy0", {31'd0, busy0}, 32'd1);
        chk("reset busy1", {31'd0, busy1}, 32'd1);
        chk("reset busy2", {31'd0, busy2}, 32'd0);
        chk("reset dout0", dout0, 32'd0);
        chk("reset dv0", {31'd0, dv0}, 32'd0);

        // Clear length; u2 (no clear) gets zero-initialised through dropped-for-u0/u1 writes.
        rstn = 1'b1;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy0) break;
            idle();
            we = 1'b1; waddr = n[3:0]; din = '0; be = 4'hF;
            n++;
            tick();
        end
        chk("clear busy cycles", n, 32'd16);
        idle();
        pulses = 0;
        for (int a = 0; a < 16; a++) begin
            rd(a[3:0]);
            if (dv0) pulses++;
        end
        idle();
        tick();
        chk("clear read pulses", pulses, 32'd16);

        // Byte-lane merge
        wr(4'd3, 32'hAABB_CCDD, 4'hF);
        wr(4'd3, 32'h1122_3344, 4'b0101);
        rd(4'd3);
        chk("merge dout0", dout0, 32'hAA22_CC44);
        chk("merge dv1 early", {31'd0, dv1}, 32'd0);
        idle();
        tick();
        chk("merge dout1", dout1, 32'hAA22_CC44);
        chk("merge dv1", {31'd0, dv1}, 32'd1);

        // Read-during-write collision
        idle();
        we = 1'b1; waddr = 4'd5; din = 32'hDEAD_BEEF; be = 4'b0011;
        re = 1'b1; raddr = 4'd5;
        tick();
        chk("rdw new dout0", dout0, 32'h0000_BEEF);
        idle();
        tick();
        chk("rdw old dout1", dout1, 32'h0000_0000);
        rd(4'd5);
        chk("rdw after dout0", dout0, 32'h0000_BEEF);
        idle();
        tick();
        chk("rdw after dout1", dout1, 32'h0000_BEEF);

        // Latency-2 pipeline; the write to addr 1 lands right after its read
        wr(4'd1, 32'd1, 4'hF);
        wr(4'd2, 32'd2, 4'hF);
        wr(4'd3, 32'd3, 4'hF);
        rd(4'd1);
        chk("lat2 first dv1", {31'd0, dv1}, 32'd0);
        idle();
        re = 1'b1; raddr = 4'd2;
        we = 1'b1; waddr = 4'd1; din = 32'h99; be = 4'hF;
        tick();
        chk("lat2 dout1 a1", dout1, 32'd1);
        rd(4'd3);
        chk("lat2 dout1 a2", dout1, 32'd2);
        idle();
        tick();
        chk("lat2 dout1 a3", dout1, 32'd3);
        chk("lat2 dv1 a3", {31'd0, dv1}, 32'd1);
        tick();
        chk("lat2 hold dout1", dout1, 32'd3);
        chk("lat2 hold dv1", {31'd0, dv1}, 32'd0);

        // Reset in the middle of a clear
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        repeat (7) tick();
        chk("midclear busy0", {31'd0, busy0}, 32'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy0) break;
            idle();
            if (n == 0) begin
                we = 1'b1; waddr = 4'd2; din = 32'h55; be = 4'hF;
            end
            n++;
            tick();
        end
        chk("restart busy cycles", n, 32'd16);
        rd(4'd2);
        chk("dropped write dout0", dout0, 32'd0);
        chk("u2 write during busy", {20'd0, dout2}, 32'h055);

        // Partial top lane on the 12-bit instance
        wr(4'd7, 32'h0000_0FFF, 4'b0011);
        wr(4'd7, 32'h0000_0000, 4'b0010);
        rd(4'd7);
        chk("partial lane dout2", {20'd0, dout2}, 32'h0FF);
        chk("partial lane dout0", dout0, 32'h0000_00FF);

        // Independent read and write on different addresses
        idle();
        we = 1'b1; waddr = 4'd8; din = 32'h1234_5678; be = 4'hF;
        re = 1'b1; raddr = 4'd7;
        tick();
        chk("indep read dout0", dout0, 32'h0000_00FF);
        rd(4'd8);
        chk("indep write dout0", dout0, 32'h1234_5678);

        idle();
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
